store_retire_ctrl: RTL and testbench

Store retire controller sitting between the completion stage and the data-memory write port. It accepts up to two completed store instructions per cycle from completion, each a 32-bit data word and a 32-bit address. It buffers them in order in a small circular FIFO and drains them one at a time to data memory over a req/ack handshake. Each finished write produces a retire pulse, so the ROB knows a store is architecturally done.

---
 rtl/store_retire_ctrl_if.sv | 34 +++
 rtl/store_retire_ctrl.sv | 101 ++++++++++
 tb/tb_store_retire_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_retire_ctrl_if.sv
// Completion-to-memory store bundle for store_retire_ctrl.
// master is the environment side, slave is the controller side.
interface store_retire_ctrl_if #(
    parameter int DEPTH = 4
);
    logic [63:0]              completed_inst_0;
    logic [63:0]              completed_inst_1;
    logic                     completed_inst_0_valid;
    logic                     completed_inst_1_valid;
    logic                     store_ready;
    logic                     mem_req;
    logic [31:0]              mem_addr;
    logic [31:0]              mem_wdata;
    logic                     mem_ack;
    logic                     store_retired;
    logic [$clog2(DEPTH):0]   buf_count;
    logic                     overflow_err;

    modport master (
        output completed_inst_0, completed_inst_1,
        output completed_inst_0_valid, completed_inst_1_valid,
        output mem_ack,
        input  store_ready, mem_req, mem_addr, mem_wdata,
        input  store_retired, buf_count, overflow_err
    );

    modport slave (
        input  completed_inst_0, completed_inst_1,
        input  completed_inst_0_valid, completed_inst_1_valid,
        input  mem_ack,
        output store_ready, mem_req, mem_addr, mem_wdata,
        output store_retired, buf_count, overflow_err
    );
endinterface

// File: rtl/store_retire_ctrl.sv
// Store retire controller: buffers up to two completed stores per cycle
// in a circular FIFO and drains them in order over a req/ack write port.
module store_retire_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    store_retire_ctrl_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t        state_q;
    logic [63:0]   fifo_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW-1:0] wr1_idx;
    logic [CW-1:0] count_q, count_d, rem;
    logic          ovf_q;
    logic          mem_req_q, retired_q;
    logic [31:0]   mem_addr_q, mem_wdata_q;
    logic          ready, push0, push1, pop;
    logic [63:0]   first_in, next_head;

    assign ready = count_q <= CW'(DEPTH - 2);
    assign push0 = bus.completed_inst_0_valid & ready;
    assign push1 = bus.completed_inst_1_valid & ready;
    assign pop   = mem_req_q & bus.mem_ack;

    always_comb begin
        tail_d    = tail_q + PW'(push0) + PW'(push1);
        wr1_idx   = push0 ? tail_q + PW'(1) : tail_q;
        head_d    = head_q + PW'(pop);
        count_d   = count_q + CW'(push0) + CW'(push1) - CW'(pop);
        rem       = count_q - CW'(pop);
        first_in  = push0 ? bus.completed_inst_0 : bus.completed_inst_1;
        // An empty FIFO means the new head is being written this very edge
        next_head = (rem == '0) ? first_in : fifo_q[head_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push0) fifo_q[tail_q] <= bus.completed_inst_0;
            if (push1) fifo_q[wr1_idx] <= bus.completed_inst_1;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if ((bus.completed_inst_0_valid | bus.completed_inst_1_valid) & ~ready)
                ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            retired_q   <= 1'b0;
        end else begin
            retired_q <= pop;
            unique case (state_q)
                IDLE: begin
                    if (count_d != '0) begin
                        state_q     <= ISSUE;
                        mem_req_q   <= 1'b1;
                        mem_addr_q  <= next_head[31:0];
                        mem_wdata_q <= next_head[63:32];
                    end
                end
                ISSUE: begin
                    if (pop) begin
                        if (count_d != '0) begin
                            mem_addr_q  <= next_head[31:0];
                            mem_wdata_q <= next_head[63:32];
                        end else begin
                            state_q   <= IDLE;
                            mem_req_q <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.store_ready   = ready;
    assign bus.mem_req       = mem_req_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign bus.store_retired = retired_q;
    assign bus.buf_count     = count_q;
    assign bus.overflow_err  = ovf_q;
endmodule

// File: tb/tb_store_retire_ctrl.sv
// Directed bench for store_retire_ctrl: push ordering, back-pressure,
// wrap-around draining, spurious ack and mid-transaction reset.
module tb_store_retire_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [63:0] seen [$];

    store_retire_ctrl_if #(.DEPTH(4)) bus ();

    store_retire_ctrl #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every accepted write as {data, addr}
    always @(posedge clk)
        if (rst_n && bus.mem_req && bus.mem_ack)
            seen.push_back({bus.mem_wdata, bus.mem_addr});

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.completed_inst_0       = '0;
        bus.completed_inst_1       = '0;
        bus.completed_inst_0_valid = 1'b0;
        bus.completed_inst_1_valid = 1'b0;
        bus.mem_ack                = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #12;
        checks++;
        if (bus.mem_req !== 1'b0 || bus.buf_count !== 3'd0 ||
            bus.store_ready !== 1'b1 || bus.overflow_err !== 1'b0 ||
            bus.store_retired !== 1'b0 || bus.mem_addr !== 32'd0 ||
            bus.mem_wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: req=%b cnt=%0d rdy=%b ovf=%b ret=%b addr=%h wd=%h",
                     bus.mem_req, bus.buf_count, bus.store_ready,
                     bus.overflow_err, bus.store_retired, bus.mem_addr,
                     bus.mem_wdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.mem_req !== 1'b0 || bus.buf_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_release: req=%b cnt=%0d want 0 0",
                     bus.mem_req, bus.buf_count);
        end
    endtask

    task automatic test_single();
        seen.delete();
        bus.completed_inst_0       = {32'hDEADBEEF, 32'h00000100};
        bus.completed_inst_0_valid = 1'b1;
        tick();
        bus.completed_inst_0_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100 ||
                bus.mem_wdata !== 32'hDEADBEEF || bus.buf_count !== 3'd1) begin
                errors++;
                $display("FAIL single_req[%0d]: req=%b addr=%h wd=%h cnt=%0d want 1 100 deadbeef 1",
                         c, bus.mem_req, bus.mem_addr, bus.mem_wdata, bus.buf_count);
            end
            if (c == 0) tick();
        end
        tick();
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        checks++;
        if (bus.store_retired !== 1'b1 || bus.mem_req !== 1'b0 ||
            bus.buf_count !== 3'd0) begin
            errors++;
            $display("FAIL single_retire: ret=%b req=%b cnt=%0d want 1 0 0",
                     bus.store_retired, bus.mem_req, bus.buf_count);
        end
        tick();
        checks++;
        if (bus.store_retired !== 1'b0 || seen.size() != 1) begin
            errors++;
            $display("FAIL single_pulse: ret=%b writes=%0d want 0 1",
                     bus.store_retired, seen.size());
        end
    endtask

    task automatic test_dual_order();
        logic [31:0] exp_a [3];
        exp_a = '{32'h10, 32'h20, 32'h30};
        seen.delete();
        bus.completed_inst_0       = {32'hAAAA0001, 32'h10};
        bus.completed_inst_1       = {32'hBBBB0002, 32'h20};
        bus.completed_inst_0_valid = 1'b1;
        bus.completed_inst_1_valid = 1'b1;
        tick();
        bus.completed_inst_0_valid = 1'b0;
        bus.completed_inst_1       = {32'hCCCC0003, 32'h30};
        checks++;
        if (bus.buf_count !== 3'd2 || bus.mem_addr !== 32'h10 ||
            bus.store_ready !== 1'b1) begin
            errors++;
            $display("FAIL dual_push: cnt=%0d addr=%h rdy=%b want 2 10 1",
                     bus.buf_count, bus.mem_addr, bus.store_ready);
        end
        tick();
        bus.completed_inst_1_valid = 1'b0;
        checks++;
        if (bus.buf_count !== 3'd3 || bus.store_ready !== 1'b0) begin
            errors++;
            $display("FAIL dual_peak: cnt=%0d rdy=%b want 3 0",
                     bus.buf_count, bus.store_ready);
        end
        bus.mem_ack = 1'b1;
        tick();
        tick();
        tick();
        bus.mem_ack = 1'b0;
        checks++;
        if (seen.size() != 3 || bus.mem_req !== 1'b0 || bus.buf_count !== 3'd0) begin
            errors++;
            $display("FAIL dual_drain: writes=%0d req=%b cnt=%0d want 3 0 0",
                     seen.size(), bus.mem_req, bus.buf_count);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (seen[i][31:0] !== exp_a[i]) begin
                    errors++;
                    $display("FAIL dual_order[%0d]: addr=%h want %h",
                             i, seen[i][31:0], exp_a[i]);
                end
            end
        end
    endtask

    task automatic test_full();
        seen.delete();
        bus.completed_inst_0       = {32'h4, 32'h40};
        bus.completed_inst_1       = {32'h5, 32'h50};
        bus.completed_inst_0_valid = 1'b1;
        bus.completed_inst_1_valid = 1'b1;
        tick();
        bus.completed_inst_0       = {32'h6, 32'h60};
        bus.completed_inst_1       = {32'h7, 32'h70};
        tick();
        bus.completed_inst_1_valid = 1'b0;
        bus.completed_inst_0       = {32'h8, 32'h80};
        checks++;
        if (bus.buf_count !== 3'd4 || bus.store_ready !== 1'b0 ||
            bus.overflow_err !== 1'b0) begin
            errors++;
            $display("FAIL full_state: cnt=%0d rdy=%b ovf=%b want 4 0 0",
                     bus.buf_count, bus.store_ready, bus.overflow_err);
        end
        tick();
        bus.completed_inst_0_valid = 1'b0;
        checks++;
        if (bus.buf_count !== 3'd4 || bus.overflow_err !== 1'b1) begin
            errors++;
            $display("FAIL full_overflow: cnt=%0d ovf=%b want 4 1",
                     bus.buf_count, bus.overflow_err);
        end
        bus.mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        bus.mem_ack = 1'b0;
        tick();
        checks++;
        if (seen.size() != 4 || bus.overflow_err !== 1'b1 ||
            bus.buf_count !== 3'd0) begin
            errors++;
            $display("FAIL full_drain: writes=%0d ovf=%b cnt=%0d want 4 1 0",
                     seen.size(), bus.overflow_err, bus.buf_count);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (seen[i] !== {32'(i + 4), 32'(8'h40 + 16 * i)}) begin
                    errors++;
                    $display("FAIL full_order[%0d]: got=%h want %h", i, seen[i],
                             {32'(i + 4), 32'(8'h40 + 16 * i)});
                end
            end
        end
    endtask

    task automatic test_wrap();
        int sent;
        int maxcnt;
        int cyc;
        do_reset();
        seen.delete();
        sent   = 0;
        maxcnt = 0;
        cyc    = 0;
        bus.mem_ack = 1'b1;
        while ((sent < 10 || bus.buf_count != 0) && cyc < 60) begin
            if (int'(bus.buf_count) > maxcnt) maxcnt = int'(bus.buf_count);
            bus.completed_inst_0_valid = 1'b0;
            bus.completed_inst_1_valid = 1'b0;
            if (bus.store_ready && sent < 10) begin
                bus.completed_inst_0 = {32'hC0DE0000 + 32'(sent),
                                        32'h1000 + 32'(4 * sent)};
                bus.completed_inst_0_valid = 1'b1;
                sent++;
                if (sent < 10) begin
                    bus.completed_inst_1 = {32'hC0DE0000 + 32'(sent),
                                            32'h1000 + 32'(4 * sent)};
                    bus.completed_inst_1_valid = 1'b1;
                    sent++;
                end
            end
            tick();
            cyc++;
        end
        bus.completed_inst_0_valid = 1'b0;
        bus.completed_inst_1_valid = 1'b0;
        tick();
        bus.mem_ack = 1'b0;
        checks++;
        if (cyc >= 60 || seen.size() != 10 || maxcnt > 4 ||
            bus.overflow_err !== 1'b0 || bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL wrap_drain: cyc=%0d writes=%0d max=%0d ovf=%b req=%b want <60 10 <=4 0 0",
                     cyc, seen.size(), maxcnt, bus.overflow_err, bus.mem_req);
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (seen[i] !== {32'hC0DE0000 + 32'(i), 32'h1000 + 32'(4 * i)}) begin
                    errors++;
                    $display("FAIL wrap_order[%0d]: got=%h want %h", i, seen[i],
                             {32'hC0DE0000 + 32'(i), 32'h1000 + 32'(4 * i)});
                end
            end
        end
    endtask

    task automatic test_spurious_reset();
        seen.delete();
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        checks++;
        if (bus.store_retired !== 1'b0 || bus.buf_count !== 3'd0 ||
            bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL spurious_ack: ret=%b cnt=%0d req=%b want 0 0 0",
                     bus.store_retired, bus.buf_count, bus.mem_req);
        end
        bus.completed_inst_0       = {32'h11111111, 32'h200};
        bus.completed_inst_1       = {32'h22222222, 32'h204};
        bus.completed_inst_0_valid = 1'b1;
        bus.completed_inst_1_valid = 1'b1;
        tick();
        bus.completed_inst_0_valid = 1'b0;
        bus.completed_inst_1_valid = 1'b0;
        checks++;
        if (bus.mem_req !== 1'b1 || bus.buf_count !== 3'd2) begin
            errors++;
            $display("FAIL pre_reset: req=%b cnt=%0d want 1 2",
                     bus.mem_req, bus.buf_count);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.mem_req !== 1'b0 || bus.buf_count !== 3'd0 ||
            bus.store_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: req=%b cnt=%0d rdy=%b want 0 0 1",
                     bus.mem_req, bus.buf_count, bus.store_ready);
        end
        bus.mem_ack = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bus.store_retired !== 1'b0 || bus.mem_req !== 1'b0 ||
                bus.buf_count !== 3'd0) begin
                errors++;
                $display("FAIL post_reset[%0d]: ret=%b req=%b cnt=%0d want 0 0 0",
                         i, bus.store_retired, bus.mem_req, bus.buf_count);
            end
        end
        bus.mem_ack = 1'b0;
        checks++;
        if (seen.size() != 0) begin
            errors++;
            $display("FAIL no_writes: writes=%0d want 0", seen.size());
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_dual_order();
        test_full();
        test_wrap();
        test_spurious_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
